// File: rtl/riscv.sv
// Shared RV32IM decode types: opcodes, control word fields and the NOP control word.
package riscv;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;

  // OP2_FOUR gives the link value pc+4 for JAL/JALR.
  typedef enum logic [2:0] {OP2_RS2, OP2_I_IMM, OP2_S_IMM, OP2_U_IMM, OP2_FOUR} op2_sel_e;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef enum logic [3:0] {
    JMP_NONE, JMP_JAL, JMP_JALR, JMP_BEQ, JMP_BNE, JMP_BLT, JMP_BGE, JMP_BLTU, JMP_BGEU
  } jmp_op_e;

  typedef struct packed {
    logic     reg_en;
    alu_op_e  alu_op;
    op1_sel_e op1_sel;
    op2_sel_e op2_sel;
    mem_op_e  mem_op;
    jmp_op_e  jmp_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_NOP = '{
    reg_en:  1'b0,
    alu_op:  ALU_ADD,
    op1_sel: OP1_RS1,
    op2_sel: OP2_RS2,
    mem_op:  MEM_NONE,
    jmp_op:  JMP_NONE
  };

  function automatic logic is_load(input mem_op_e m);
    return m inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

endpackage

// File: rtl/decode_stage.sv
// ID/EX pipeline register: decodes RV32I (+ optional RV32M) with strict funct7 checks,
// valid/ready on both sides, load-use interlock, flush and a saturating illegal counter.
module decode_stage
  import riscv::*;
#(
  parameter bit          ENABLE_M           = 1'b1,
  parameter bit          LOAD_USE_INTERLOCK = 1'b1,
  parameter int unsigned ILL_CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic                 out_muldiv,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_inst,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign funct7 = in_inst[31:25];

  ctrl_t dec_ctrl;
  logic  dec_illegal, dec_muldiv, uses_rs1, uses_rs2;

  ctrl_t                ctrl_q;
  logic                 valid_q, illegal_q, muldiv_q;
  logic [4:0]           rd_q, rs1_q, rs2_q;
  logic [31:0]          pc_q, inst_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;

  logic load_en, hazard, accept;

  // Decode the presented instruction; any illegal encoding collapses to the NOP control word.
  always_comb begin
    dec_ctrl    = CTRL_NOP;
    dec_illegal = 1'b0;
    dec_muldiv  = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_ctrl.reg_en  = 1'b1;
        dec_ctrl.op1_sel = OP1_ZERO;
        dec_ctrl.op2_sel = OP2_U_IMM;
      end
      OPC_AUIPC: begin
        dec_ctrl.reg_en  = 1'b1;
        dec_ctrl.op1_sel = OP1_PC;
        dec_ctrl.op2_sel = OP2_U_IMM;
      end
      OPC_JAL: begin
        dec_ctrl.reg_en  = 1'b1;
        dec_ctrl.op1_sel = OP1_PC;
        dec_ctrl.op2_sel = OP2_FOUR;
        dec_ctrl.jmp_op  = JMP_JAL;
      end
      OPC_JALR: begin
        uses_rs1         = 1'b1;
        dec_ctrl.reg_en  = 1'b1;
        dec_ctrl.op1_sel = OP1_PC;
        dec_ctrl.op2_sel = OP2_FOUR;
        dec_ctrl.jmp_op  = JMP_JALR;
        dec_illegal      = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl.jmp_op = JMP_BEQ;
          3'b001:  dec_ctrl.jmp_op = JMP_BNE;
          3'b100:  dec_ctrl.jmp_op = JMP_BLT;
          3'b101:  dec_ctrl.jmp_op = JMP_BGE;
          3'b110:  dec_ctrl.jmp_op = JMP_BLTU;
          3'b111:  dec_ctrl.jmp_op = JMP_BGEU;
          default: dec_illegal     = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        uses_rs1         = 1'b1;
        dec_ctrl.reg_en  = 1'b1;
        dec_ctrl.op2_sel = OP2_I_IMM;
        case (funct3)
          3'b000:  dec_ctrl.mem_op = MEM_LB;
          3'b001:  dec_ctrl.mem_op = MEM_LH;
          3'b010:  dec_ctrl.mem_op = MEM_LW;
          3'b100:  dec_ctrl.mem_op = MEM_LBU;
          3'b101:  dec_ctrl.mem_op = MEM_LHU;
          default: dec_illegal     = 1'b1;
        endcase
      end
      OPC_STORE: begin
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        dec_ctrl.op2_sel = OP2_S_IMM;
        case (funct3)
          3'b000:  dec_ctrl.mem_op = MEM_SB;
          3'b001:  dec_ctrl.mem_op = MEM_SH;
          3'b010:  dec_ctrl.mem_op = MEM_SW;
          default: dec_illegal     = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        uses_rs1         = 1'b1;
        dec_ctrl.reg_en  = 1'b1;
        dec_ctrl.op2_sel = OP2_I_IMM;
        case (funct3)
          3'b000: dec_ctrl.alu_op = ALU_ADD;
          3'b010: dec_ctrl.alu_op = ALU_SLT;
          3'b011: dec_ctrl.alu_op = ALU_SLTU;
          3'b100: dec_ctrl.alu_op = ALU_XOR;
          3'b110: dec_ctrl.alu_op = ALU_OR;
          3'b111: dec_ctrl.alu_op = ALU_AND;
          3'b001: begin
            dec_ctrl.alu_op = ALU_SLL;
            dec_illegal     = (funct7 != 7'b0000000);
          end
          default: begin
            if (funct7 == 7'b0000000)      dec_ctrl.alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) dec_ctrl.alu_op = ALU_SRA;
            else                           dec_illegal     = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        dec_ctrl.reg_en = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_ctrl.alu_op = ALU_ADD;
            3'b001:  dec_ctrl.alu_op = ALU_SLL;
            3'b010:  dec_ctrl.alu_op = ALU_SLT;
            3'b011:  dec_ctrl.alu_op = ALU_SLTU;
            3'b100:  dec_ctrl.alu_op = ALU_XOR;
            3'b101:  dec_ctrl.alu_op = ALU_SRL;
            3'b110:  dec_ctrl.alu_op = ALU_OR;
            default: dec_ctrl.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  dec_ctrl.alu_op = ALU_SUB;
            3'b101:  dec_ctrl.alu_op = ALU_SRA;
            default: dec_illegal     = 1'b1;
          endcase
        end else if (ENABLE_M && funct7 == 7'b0000001) begin
          dec_muldiv = 1'b1;
          case (funct3)
            3'b000:  dec_ctrl.alu_op = ALU_MUL;
            3'b001:  dec_ctrl.alu_op = ALU_MULH;
            3'b010:  dec_ctrl.alu_op = ALU_MULHSU;
            3'b011:  dec_ctrl.alu_op = ALU_MULHU;
            3'b100:  dec_ctrl.alu_op = ALU_DIV;
            3'b101:  dec_ctrl.alu_op = ALU_DIVU;
            3'b110:  dec_ctrl.alu_op = ALU_REM;
            default: dec_ctrl.alu_op = ALU_REMU;
          endcase
        end else begin
          dec_illegal = 1'b1;
        end
      end
      // FENCE and SYSTEM carry no datapath work in this pipeline; pass them as legal NOPs.
      OPC_MISC_MEM, OPC_SYSTEM: dec_ctrl = CTRL_NOP;
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl   = CTRL_NOP;
      dec_muldiv = 1'b0;
    end
  end

  // Load-use hazard against the instruction currently held in the output register.
  always_comb begin
    hazard = LOAD_USE_INTERLOCK && valid_q && is_load(ctrl_q.mem_op) && (rd_q != 5'd0) &&
             ((uses_rs1 && (rs1 == rd_q)) || (uses_rs2 && (rs2 == rd_q)));
    load_en  = !valid_q || out_ready;
    in_ready = load_en && !hazard;
    accept   = in_valid && in_ready;
  end

  // Output register: reset > flush > accept/bubble/hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      illegal_q <= 1'b0;
      muldiv_q  <= 1'b0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      inst_q    <= '0;
      ill_cnt_q <= '0;
    end else if (flush) begin
      // The instruction accepted this cycle is dropped and not counted.
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      illegal_q <= 1'b0;
      muldiv_q  <= 1'b0;
    end else if (load_en) begin
      if (accept) begin
        valid_q   <= 1'b1;
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_illegal;
        muldiv_q  <= dec_muldiv;
        rd_q      <= rd;
        rs1_q     <= rs1;
        rs2_q     <= rs2;
        pc_q      <= in_pc;
        inst_q    <= in_inst;
        if (dec_illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
          ill_cnt_q <= ill_cnt_q + 1'b1;
        end
      end else begin
        valid_q   <= 1'b0;
        ctrl_q    <= CTRL_NOP;
        illegal_q <= 1'b0;
        muldiv_q  <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_ctrl    = ctrl_q;
  assign out_illegal = illegal_q;
  assign out_muldiv  = muldiv_q;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_pc      = pc_q;
  assign out_inst    = inst_q;
  assign ill_count   = ill_cnt_q;

endmodule
